// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one add-and-shift per cycle over WIDTH cycles,
// sign handled by operating on magnitudes and negating the final product.
module seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     mag_a, mag_b, addend;
  logic [WIDTH:0]       sum;

  always_comb begin
    mag_a = (Signed && Multiplicand[WIDTH-1]) ? -Multiplicand : Multiplicand;
    mag_b = (Signed && Multiplier[WIDTH-1])   ? -Multiplier   : Multiplier;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    m_d       = m_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    addend    = acc_q[0] ? m_q : '0;
    // ACC[2W] is always 0 here, so using it as the top bit equals a zero-extend
    sum       = acc_q[2*WIDTH:WIDTH] + {1'b0, addend};
    case (state_q)
      IDLE: begin
        if (Start) begin
          acc_d   = {{(WIDTH+1){1'b0}}, mag_b};
          m_d     = mag_a;
          neg_d   = Signed & (Multiplicand[WIDTH-1] ^ Multiplier[WIDTH-1]);
          cnt_d   = CW'(WIDTH-1);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FINISH;
      end
      FINISH: begin
        product_d = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      m_q       <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign Product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed checks of seq_multiplier against an arithmetic reference.
module tb_seq_multiplier;

  localparam int unsigned W = 16;

  logic           Clk, Rst, Start, Signed;
  logic [W-1:0]   Multiplicand, Multiplier;
  logic           Busy, Done;
  logic [2*W-1:0] Product;

  int n_checks = 0;
  int n_pass   = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Signed(Signed),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .Busy(Busy), .Done(Done), .Product(Product)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'({1'b0, a}) * longint'({1'b0, b});
    return p[2*W-1:0];
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge Clk); #1;
      cyc++;
    end while (!Done && cyc < 40);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [2*W-1:0] exp_p);
    int cyc;
    @(negedge Clk);
    Start = 1'b1; Signed = s; Multiplicand = a; Multiplier = b;
    @(posedge Clk); #1;
    check({tag, "_busy"}, 64'(Busy), 64'(1));
    @(negedge Clk);
    Start = 1'b0;
    Multiplicand = W'($urandom); Multiplier = W'($urandom); Signed = 1'($urandom);
    wait_done(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(W + 1));
    check({tag, "_prod"}, 64'(Product), 64'(exp_p));
    check({tag, "_busy_done"}, 64'(Busy), 64'(0));
    @(posedge Clk); #1;
    check({tag, "_done_width"}, 64'(Done), 64'(0));
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t dir[7];
  logic [W-1:0] corners[5];

  initial begin
    int cyc, seen;
    logic [W-1:0] ra, rb;
    logic rs;

    dir[0] = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F};
    dir[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    dir[2] = '{16'h0000, 16'h1234, 1'b0, 32'h00000000};
    dir[3] = '{16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB};
    dir[4] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    dir[5] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000};
    dir[6] = '{16'h0000, 16'hFFFF, 1'b1, 32'h00000000};
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

    Rst = 1'b1; Start = 1'b0; Signed = 1'b0; Multiplicand = '0; Multiplier = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", 64'(Busy), 64'(0));
    check("rst_done", 64'(Done), 64'(0));
    check("rst_prod", 64'(Product), 64'(0));
    @(negedge Clk); Rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("dir%0d", i), dir[i].a, dir[i].b, dir[i].s, dir[i].p);

    // Start while busy is ignored, then back-to-back accept in the Done cycle
    @(negedge Clk);
    Start = 1'b1; Signed = 1'b0; Multiplicand = 16'd3; Multiplier = 16'd5;
    @(posedge Clk); #1;
    check("ign_busy", 64'(Busy), 64'(1));
    @(negedge Clk); Start = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    Start = 1'b1; Signed = 1'b1; Multiplicand = 16'd100; Multiplier = 16'd200;
    @(posedge Clk);
    @(negedge Clk); Start = 1'b0;
    wait_done(cyc);
    check("ign_lat", 64'(cyc), 64'(W + 1 - 5));
    check("ign_prod", 64'(Product), 64'(32'h0000000F));
    Start = 1'b1; Signed = 1'b0; Multiplicand = 16'h1234; Multiplier = 16'h0100;
    @(posedge Clk); #1;
    check("b2b_busy", 64'(Busy), 64'(1));
    check("b2b_done_drop", 64'(Done), 64'(0));
    @(negedge Clk); Start = 1'b0;
    wait_done(cyc);
    check("b2b_lat", 64'(cyc), 64'(W + 1));
    check("b2b_prod", 64'(Product), 64'(32'h00123400));

    // Asynchronous reset in the middle of RUN
    @(negedge Clk);
    Start = 1'b1; Signed = 1'b0; Multiplicand = 16'h1111; Multiplier = 16'h0003;
    @(posedge Clk);
    @(negedge Clk); Start = 1'b0;
    repeat (8) @(posedge Clk);
    #3 Rst = 1'b1;
    #1;
    check("arst_busy", 64'(Busy), 64'(0));
    check("arst_done", 64'(Done), 64'(0));
    check("arst_prod", 64'(Product), 64'(0));
    @(negedge Clk); Rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge Clk); #1;
      if (Done) seen++;
    end
    check("arst_no_done", 64'(seen), 64'(0));
    check("arst_prod_hold", 64'(Product), 64'(0));
    run_op("post_rst", 16'h1111, 16'h0003, 1'b0, 32'h00003333);

    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      rs = 1'($urandom);
      run_op($sformatf("rnd%0d_%0h_%0h_s%0d", i, ra, rb, rs), ra, rb, rs, ref_mul(ra, rb, rs));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
